// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings and FSM state encoding shared by the iterative multiply/divide unit.
package mdu_pkg;
   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FIX, ST_DONE} mdu_state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate; with neg_i = sign bit it yields |x|.
module mdu_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] x_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);
   assign y_o = neg_i ? -x_i : x_i;
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: iterative MULT/MULTU/DIV/DIVU unit with valid/ready handshake, cancel and held result.
// Define MDU_EARLY_EXIT_EN to end a multiply once the remaining multiplier bits are all zero.
module alu_mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   mdu_state_e st_q;
   logic [CW-1:0] cnt_q;
   logic div_q, neg_lo_q, neg_hi_q, bz_q, ov_q, dz_q, last;
   logic [WIDTH-1:0] a_q, mp_q, hi_q, lo_q, ma, mb, q_fix, r_fix;
   logic [2*WIDTH-1:0] acc_q, mc_q, acc_d, p_fix;
   logic [WIDTH:0] diff;
   logic sa, sb;
   assign sa = ~op[0] & a[WIDTH-1];
   assign sb = ~op[0] & b[WIDTH-1];
   mdu_sign_fix #(.W(WIDTH)) u_abs_a (.x_i(a), .neg_i(sa), .y_o(ma));
   mdu_sign_fix #(.W(WIDTH)) u_abs_b (.x_i(b), .neg_i(sb), .y_o(mb));
   mdu_sign_fix #(.W(2*WIDTH)) u_fix_p (.x_i(acc_q), .neg_i(neg_lo_q), .y_o(p_fix));
   mdu_sign_fix #(.W(WIDTH)) u_fix_q (.x_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .y_o(q_fix));
   mdu_sign_fix #(.W(WIDTH)) u_fix_r (.x_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_hi_q), .y_o(r_fix));
   // divide keeps {remainder, dividend/quotient} in acc; multiply accumulates the product there
   always_comb begin
      diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mc_q[WIDTH-1:0]};
      acc_d = div_q ? (diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                    : (mp_q[0] ? acc_q + mc_q : acc_q);
   end
`ifdef MDU_EARLY_EXIT_EN
   assign last = ~div_q & (mp_q[WIDTH-1:1] == '0);
`else
   assign last = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q     <= ST_IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         bz_q     <= 1'b0;
         a_q      <= '0;
         mp_q     <= '0;
         acc_q    <= '0;
         mc_q     <= '0;
         ov_q     <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (cancel) begin
         st_q <= ST_IDLE;
         ov_q <= 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: if (in_valid) begin
               st_q     <= ST_BUSY;
               cnt_q    <= CW'(WIDTH);
               div_q    <= op[1];
               neg_lo_q <= sa ^ sb;
               neg_hi_q <= sa;
               bz_q     <= b == '0;
               a_q      <= a;
               mp_q     <= mb;
               acc_q    <= op[1] ? {{WIDTH{1'b0}}, ma} : '0;
               mc_q     <= {{WIDTH{1'b0}}, op[1] ? mb : ma};
            end
            ST_BUSY: if (cnt_q == '0) st_q <= ST_FIX;
            else begin
               acc_q <= acc_d;
               mc_q  <= div_q ? mc_q : mc_q << 1;
               mp_q  <= mp_q >> 1;
               cnt_q <= last ? '0 : cnt_q - CW'(1);
            end
            ST_FIX: begin
               st_q <= ST_DONE;
               ov_q <= 1'b1;
               dz_q <= div_q & bz_q;
               lo_q <= !div_q ? p_fix[WIDTH-1:0] : bz_q ? '1 : q_fix;
               hi_q <= !div_q ? p_fix[2*WIDTH-1:WIDTH] : bz_q ? a_q : r_fix;
            end
            ST_DONE: if (out_ready) begin
               st_q <= ST_IDLE;
               ov_q <= 1'b0;
            end
         endcase
      end
   end
   assign in_ready  = st_q == ST_IDLE;
   assign busy      = st_q != ST_IDLE;
   assign out_valid = ov_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign div_zero  = dz_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors against an arithmetic reference model for alu_mdu (WIDTH=32).
module tb_alu_mdu;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, cancel = 1'b0, out_ready = 1'b0;
   logic [1:0] op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic in_ready, out_valid, div_zero, busy;
   logic [31:0] hi, lo;
   int n_cmp = 0, n_err = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0, held_hi = '0, held_lo = '0;
   logic exp_dz = 1'b0, held_dz = 1'b0;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .cancel(cancel), .out_valid(out_valid), .out_ready(out_ready),
      .hi(hi), .lo(lo), .div_zero(div_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // reference: plain SV arithmetic (signed division truncates toward zero)
   function automatic void model(input logic [1:0] o, input logic [31:0] x, y,
                                 output logic [31:0] eh, el, output logic ed);
      longint sx, sy;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      ed = 1'b0;
      if (!o[1]) begin
         p = o[0] ? {32'b0, x} * {32'b0, y} : 64'(sx * sy);
         {eh, el} = p;
      end else if (y == 0) begin
         el = '1;
         eh = x;
         ed = 1'b1;
      end else if (o[0]) begin
         el = x / y;
         eh = x % y;
      end else begin
         el = 32'(sx / sy);
         eh = 32'(sx % sy);
      end
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
      int it;
      logic [31:0] m;
      it = 1;
      m = (!o[0] && y[31]) ? -y : y;
      for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
`ifdef MDU_EARLY_EXIT_EN
      return o[1] ? 34 : it + 2;
`else
      return (it > 0) ? 34 : 0;
`endif
   endfunction

   // compare process: live result while valid, held result otherwise
   always @(negedge clk) begin
      if (reset) begin
         held_hi <= '0;
         held_lo <= '0;
         held_dz <= 1'b0;
      end else if (out_valid) begin
         chk("hi", hi, exp_hi);
         chk("lo", lo, exp_lo);
         chk("div_zero", div_zero, exp_dz);
         chk("in_ready_in_done", in_ready, 0);
         held_hi <= hi;
         held_lo <= lo;
         held_dz <= div_zero;
      end else begin
         chk("held_hi", hi, held_hi);
         chk("held_lo", lo, held_lo);
         chk("held_dz", div_zero, held_dz);
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, input int hold);
      int n;
      logic [31:0] eh, el;
      logic ed;
      model(o, x, y, eh, el, ed);
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      chk("ready_before_issue", in_ready, 1);
      exp_hi = eh; exp_lo = el; exp_dz = ed;
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      chk("latency", n, exp_lat(o, y));
      repeat (hold) begin @(posedge clk); #1; end
      chk("valid_under_backpressure", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after_consume", in_ready, 1);
      chk("valid_drop_after_consume", out_valid, 0);
   endtask

   initial begin
      logic [31:0] eh, el;
      logic ed;
      bit seen;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_busy", busy, 0);
      model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, eh, el, ed); chk("pin_multu", {eh, el}, 64'hFFFFFFFE_00000001);
      model(2'b00, -32'sd3, 32'd5, eh, el, ed);             chk("pin_mult", {eh, el}, 64'hFFFFFFFF_FFFFFFF1);
      model(2'b10, -32'sd7, 32'd2, eh, el, ed);             chk("pin_div", {eh, el}, 64'hFFFFFFFF_FFFFFFFD);
      model(2'b10, 32'h80000000, 32'hFFFFFFFF, eh, el, ed); chk("pin_div_min", {eh, el}, 64'h00000000_80000000);
      model(2'b11, 32'd5, 32'd0, eh, el, ed);               chk("pin_divu_zero", {ed, eh, el}, {1'b1, 64'h00000005_FFFFFFFF});
      model(2'b10, -32'sd5, 32'd0, eh, el, ed);             chk("pin_div_zero", {ed, eh, el}, {1'b1, 64'hFFFFFFFB_FFFFFFFF});
      @(posedge clk); #1;
      reset = 1'b0;
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(2'b00, -32'sd3, 32'd5, 0);
      run_op(2'b10, -32'sd7, 32'd2, 5);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'b11, 32'd5, 32'd0, 0);
      run_op(2'b10, -32'sd5, 32'd0, 0);
      run_op(2'b01, 32'd3, 32'd1, 0);
      run_op(2'b11, 32'd7, 32'd2, 0);
      run_op(2'b00, 32'h80000000, 32'h80000000, 0);
      run_op(2'b11, 32'd100, 32'd7, 0);
      run_op(2'b10, 32'd100, -32'sd7, 0);
      run_op(2'b00, 32'h12345678, 32'd0, 0);
      // cancel mid-computation
      op = 2'b01; a = 32'd9; b = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel_in_ready", in_ready, 1);
      chk("cancel_busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      chk("cancel_no_valid", seen, 0);
      // cancel together with in_valid: nothing accepted
      in_valid = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; cancel = 1'b0;
      chk("cancel_wins_busy", busy, 0);
      chk("cancel_wins_ready", in_ready, 1);
      // reset in the middle of BUSY
      op = 2'b10; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_div_zero", div_zero, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      run_op(2'b11, 32'd1000, 32'd3, 2);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
